// File: rtl/iir_frame_sched.sv
// Frame scheduler in front of a free-running IIR filter.
// Collects FRAME input samples, bursts them into the filter followed by TAIL
// zeros, and captures each filter result LAT clocks later into an output FIFO.
// The filter is held cleared between frames.
// Optional feature: define IIR_SCHED_OVF_EN to add ovf_cnt, a saturating count
// of captured results at full-scale (+max or -max).
module iir_frame_sched #(
  parameter int W     = 11,
  parameter int FRAME = 16,
  parameter int TAIL  = 8,
  parameter int LAT   = 1,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         iir_rst,
  output logic [W-1:0] iir_x,
  input  logic [W-1:0] iir_z,
  output logic         busy
`ifdef IIR_SCHED_OVF_EN
  ,
  output logic [7:0]   ovf_cnt
`endif
);

  localparam int IW   = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int NW   = $clog2(FRAME + 1);
  localparam int CW   = $clog2(FRAME + TAIL + LAT + 1);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW   = $clog2(DEPTH + 1);
  localparam int NEED = FRAME + TAIL;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_TAIL,
    S_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;

  logic [W-1:0]    r_buf [FRAME];
  logic [NW-1:0]   r_in_cnt;

  logic            r_iir_rst;
  logic [W-1:0]    r_iir_x;
  logic            r_busy;
  logic            r_xv;
  logic [LAT-1:0]  r_cap;

  logic [W-1:0]    r_mem [DEPTH];
  logic [PW-1:0]   r_wp;
  logic [PW-1:0]   r_rp;
  logic [OW-1:0]   r_ocnt;

  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_space_ok;
  logic            w_frame_done;

  // Handshake and status decode
  assign in_ready     = (r_state == S_IDLE) && (r_in_cnt < NW'(FRAME)) && !abort && !rst;
  assign w_accept     = in_valid && in_ready;
  assign out_valid    = (r_ocnt != '0);
  assign out_data     = r_mem[r_rp];
  assign w_pop        = out_valid && out_ready;
  assign w_push       = r_cap[LAT-1];
  // Pops in the current cycle are deliberately not credited as free space.
  assign w_space_ok   = (r_ocnt <= OW'(DEPTH - NEED));
  assign w_frame_done = (r_state == S_DRAIN) && (w_state_nxt == S_IDLE);

  assign iir_rst = r_iir_rst;
  assign iir_x   = r_iir_x;
  assign busy    = r_busy;

  // Next-state and phase counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if ((r_in_cnt == NW'(FRAME)) && w_space_ok) begin
            w_state_nxt = S_BURST;
            w_cnt_nxt   = '0;
          end
        end
        S_BURST: begin
          if (r_cnt == CW'(FRAME - 1)) begin
            w_state_nxt = (TAIL == 0) ? S_DRAIN : S_TAIL;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_TAIL: begin
          if (r_cnt == CW'(TAIL - 1)) begin
            w_state_nxt = S_DRAIN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_DRAIN: begin
          if (r_cnt == CW'(LAT - 1)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State register plus registered filter-side outputs derived from next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_iir_rst <= 1'b1;
      r_iir_x   <= '0;
      r_busy    <= 1'b0;
      r_xv      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_iir_rst <= (w_state_nxt == S_IDLE);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_xv      <= (w_state_nxt == S_BURST) || (w_state_nxt == S_TAIL);
      // Sample index equals the next phase count, so iir_x lines up with the state it belongs to.
      r_iir_x   <= (w_state_nxt == S_BURST) ? r_buf[w_cnt_nxt[IW-1:0]] : '0;
    end
  end

  // Capture pipe: marks which filter outputs belong to the current frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap <= '0;
    end else if (abort) begin
      r_cap <= '0;
    end else begin
      r_cap[0] <= r_xv;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_cap[i] <= r_cap[i-1];
      end
    end
  end

  // Input sample count; cleared on abort and when a frame completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_cnt <= '0;
    end else if (abort || w_frame_done) begin
      r_in_cnt <= '0;
    end else if (w_accept) begin
      r_in_cnt <= r_in_cnt + NW'(1);
    end
  end

  // Input sample storage, written in arrival order
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_in_cnt[IW-1:0]] <= in_data;
    end
  end

  // Output FIFO storage
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= iir_z;
    end
  end

  // Output FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_ocnt <= '0;
    end else begin
      if (w_push) begin
        r_wp <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + PW'(1);
      end
      if (w_pop) begin
        r_rp <= (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_ocnt <= r_ocnt + OW'(1);
        2'b01:   r_ocnt <= r_ocnt - OW'(1);
        default: r_ocnt <= r_ocnt;
      endcase
    end
  end

`ifdef IIR_SCHED_OVF_EN
  localparam logic [W-1:0] ZMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] ZMIN = {1'b1, {(W-1){1'b0}}};
  logic [7:0] r_ovf;
  assign ovf_cnt = r_ovf;

  // Saturating count of full-scale captured results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= '0;
    end else if (w_push && ((iir_z == ZMAX) || (iir_z == ZMIN)) && (r_ovf != '1)) begin
      r_ovf <= r_ovf + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_iir_frame_sched.sv
// Directed bench for iir_frame_sched with a stand-in first-order IIR filter
// (y = sat(x + y/2), one clock latency, cleared by iir_rst).
module tb_iir_frame_sched;

  localparam int W     = 11;
  localparam int FRAME = 16;
  localparam int TAIL  = 8;
  localparam int NOUT  = FRAME + TAIL;

  logic         clk = 1'b0;
  logic         rst;
  logic         abort;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         iir_rst;
  logic [W-1:0] iir_x;
  logic [W-1:0] iir_z;
  logic         busy;
`ifdef IIR_SCHED_OVF_EN
  logic [7:0]   ovf_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  int ovf_model = 0;
  int n0;

  logic [W-1:0] fb [FRAME];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] imp_gold [NOUT] = '{11'd1023, 11'd511, 11'd255, 11'd127, 11'd63, 11'd31,
                                    11'd15, 11'd7, 11'd3, 11'd1, 11'd0, 11'd0,
                                    11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0,
                                    11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0};
  logic [W-1:0] f_y;

  iir_frame_sched #(.W(W), .FRAME(FRAME), .TAIL(TAIL), .LAT(1), .DEPTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .iir_rst  (iir_rst),
    .iir_x    (iir_x),
    .iir_z    (iir_z),
    .busy     (busy)
`ifdef IIR_SCHED_OVF_EN
    ,
    .ovf_cnt  (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] filt(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [W:0] s;
    s = $signed({x[W-1], x}) + $signed({y[W-1], y[W-1], y[W-1:1]});
    if (s > 12'sd1023) return 11'h3FF;
    else if (s < -12'sd1024) return 11'h400;
    else return s[W-1:0];
  endfunction

  // Stand-in filter: one clock from iir_x to iir_z
  always @(posedge clk) begin
    if (iir_rst) f_y <= '0;
    else         f_y <= filt(iir_x, f_y);
  end
  assign iir_z = f_y;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Output scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) check("extra_out", 32'(out_data), 32'hFFFF_FFFF);
      else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit is_full_scale(input logic [W-1:0] v);
    return (v == 11'h3FF) || (v == 11'h400);
  endfunction

  task automatic push_table(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(imp_gold[i]);
      if (is_full_scale(imp_gold[i])) ovf_model++;
    end
  endtask

  task automatic push_model(input int n);
    logic [W-1:0] y;
    logic [W-1:0] x;
    y = '0;
    for (int i = 0; i < n; i++) begin
      x = (i < FRAME) ? fb[i] : '0;
      y = filt(x, y);
      exp_q.push_back(y);
      if (is_full_scale(y)) ovf_model++;
    end
  endtask

  task automatic send_frame();
    int n;
    tick(1);
    for (int i = 0; i < FRAME; i++) begin
      in_valid = 1'b1;
      in_data  = fb[i];
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      tick(1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_busy(input string tag);
    int n;
    @(negedge clk);
    n = 0;
    while (!busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd1);
  endtask

  task automatic load_impulse();
    for (int i = 0; i < FRAME; i++) fb[i] = (i == 0) ? 11'h3FF : 11'h000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_iir_rst", 32'(iir_rst), 32'd1);
    check("rst_iir_x", 32'(iir_x), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // T1 impulse
    load_impulse();
    out_ready = 1'b1;
    push_table(NOUT);
    n0 = n_out;
    send_frame();
    @(negedge clk);
    check("t1_busy_early", 32'(busy), 32'd0);
    @(negedge clk);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_iir_rst", 32'(iir_rst), 32'd0);
    wait_drain();
    check("t1_count", 32'(n_out - n0), 32'd24);
    check("t1_idle", 32'(busy), 32'd0);

    // T2 backpressure
    out_ready = 1'b0;
    push_table(NOUT);
    n0 = n_out;
    send_frame();
    tick(30);
    @(negedge clk);
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_frozen_a", 32'(out_data), 32'h3FF);
    tick(5);
    @(negedge clk);
    check("t2_frozen_b", 32'(out_data), 32'h3FF);
    check("t2_done", 32'(busy), 32'd0);
    tick(1);
    out_ready = 1'b1;
    wait_drain();
    check("t2_count", 32'(n_out - n0), 32'd24);

    // T3 space gate
    out_ready = 1'b0;
    push_table(NOUT);
    n0 = n_out;
    send_frame();
    tick(30);
    for (int i = 0; i < FRAME; i++) fb[i] = W'(i * 90 - 600);
    push_model(NOUT);
    send_frame();
    tick(10);
    @(negedge clk);
    check("t3_gate_iir_rst", 32'(iir_rst), 32'd1);
    check("t3_gate_busy", 32'(busy), 32'd0);
    check("t3_gate_in_ready", 32'(in_ready), 32'd0);
    tick(1);
    out_ready = 1'b1;
    tick(16);
    out_ready = 1'b0;
    @(negedge clk);
    check("t3_still_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("t3_burst", 32'(busy), 32'd1);
    tick(30);
    out_ready = 1'b1;
    wait_drain();
    check("t3_count", 32'(n_out - n0), 32'd48);

    // T4 abort on 5th burst clock
    out_ready = 1'b0;
    load_impulse();
    push_table(4);
    n0 = n_out;
    send_frame();
    wait_busy("t4_busy");
    tick(4);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    @(negedge clk);
    check("t4_iir_rst", 32'(iir_rst), 32'd1);
    check("t4_busy_low", 32'(busy), 32'd0);
    check("t4_in_ready", 32'(in_ready), 32'd1);
    tick(5);
    @(negedge clk);
    check("t4_kept", 32'(out_valid), 32'd1);
    tick(1);
    out_ready = 1'b1;
    wait_drain();
    check("t4_count", 32'(n_out - n0), 32'd4);
    check("t4_empty", 32'(out_valid), 32'd0);
    push_table(NOUT);
    n0 = n_out;
    send_frame();
    wait_drain();
    check("t4_next_count", 32'(n_out - n0), 32'd24);

    // T5 async reset mid-tail
    out_ready = 1'b0;
    send_frame();
    wait_busy("t5_busy");
    tick(19);
    #1;
    rst = 1'b1;
    #1;
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check("t5_rst_in_ready", 32'(in_ready), 32'd0);
    check("t5_rst_iir_rst", 32'(iir_rst), 32'd1);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_iir_x", 32'(iir_x), 32'd0);
    tick(2);
    rst = 1'b0;
    ovf_model = 0;
    @(negedge clk);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_iir_rst", 32'(iir_rst), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    push_table(NOUT);
    n0 = n_out;
    send_frame();
    wait_drain();
    check("t5_next_count", 32'(n_out - n0), 32'd24);

`ifdef IIR_SCHED_OVF_EN
    // T6 full-scale frames drive the overflow counter to saturation
    for (int i = 0; i < FRAME; i++) fb[i] = 11'h3FF;
    for (int f = 0; f < 20; f++) begin
      push_model(NOUT);
      send_frame();
      wait_drain();
      if (f == 0) check("t6_ovf_first", 32'(ovf_cnt), 32'((ovf_model > 255) ? 255 : ovf_model));
    end
    check("t6_ovf_sat", 32'(ovf_cnt), 32'((ovf_model > 255) ? 255 : ovf_model));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
